// File: rtl/piso_tx.sv
// piso_tx: parallel-in / serial-out transmitter with a load handshake.
// A WIDTH-bit word is captured in IDLE and shifted out MSB first over a
// valid/ready serial port. After the last bit is accepted, done pulses for one cycle.
// Optional feature macro: PISO_TX_PARITY_EN. When it is defined, an even-parity
// bit follows the data bits and is carried through a PARITY state.
//
// Handshake semantics: a transfer happens on the rising edge where valid and
// ready are both high. Once valid is high it stays high, and the data stays
// stable, until that edge. Ready may toggle freely. Ready while valid is low
// is ignored.
module piso_tx #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd3
  } state_t;
`endif

  state_t          state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
`ifdef PISO_TX_PARITY_EN
  logic             par_bit;
`endif

  // Frame sequencing: capture on load, shift on each accepted bit, then finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef PISO_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            shreg   <= load_data;
            bit_cnt <= '0;
`ifdef PISO_TX_PARITY_EN
            par_bit <= ^load_data;
`endif
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // ser_valid is always high here, so ser_ready alone marks a transfer.
          if (ser_ready) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            if (bit_cnt == LAST_BIT) begin
              // The counter holds at its last value so that it never wraps.
`ifdef PISO_TX_PARITY_EN
              state <= PARITY;
`else
              state <= DONE;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef PISO_TX_PARITY_EN
        PARITY: begin
          if (ser_ready) begin
            state <= DONE;
          end
        end
`endif
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode from registered state only; no input reaches an output.
  always_comb begin
    load_ready = (state == IDLE);
    busy       = (state != IDLE);
    done       = (state == DONE);
    ser_valid  = (state == SHIFT);
    ser_out    = (state == SHIFT) & shreg[WIDTH-1];
`ifdef PISO_TX_PARITY_EN
    if (state == PARITY) begin
      ser_valid = 1'b1;
      ser_out   = par_bit;
    end
`endif
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx.
// Expected serial bits are queued when a word is loaded and are popped on
// each accepted bit.
module tb_piso_tx;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  logic         ser_valid;
  logic         ser_ready;
  logic         ser_out;
  logic         busy;
  logic         done;

  logic [0:0] exp_q[$];
  int         pass_cnt = 0;
  int         total_cnt = 0;
  bit         pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

`ifdef PISO_TX_PARITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  piso_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .ser_out    (ser_out),
    .busy       (busy),
    .done       (done)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_load_ready"}, load_ready, 1);
    check({tag, "_ser_valid"}, ser_valid, 0);
    check({tag, "_ser_out"}, ser_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // Driver: present one word and queue its expected serial bits.
  task automatic load_word(input logic [W-1:0] w);
    check("load_ready_before_load", load_ready, 1);
    load_valid = 1'b1;
    load_data  = w;
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef PISO_TX_PARITY_EN
    exp_q.push_back(^w);
`endif
    step();
    load_valid = 1'b0;
    load_data  = 16'($urandom);
    check("first_bit_valid", ser_valid, 1);
    check("busy_after_load", busy, 1);
  endtask

  // Receiver: mode 0 = always ready, 1 = fixed pattern, 2 = random.
  // Runs until done is seen, then checks the return to IDLE.
  task automatic drain(input int mode, input bit inject, output int done_cyc);
    int   cyc;
    int   pi;
    bit   stalled;
    logic prev_out;
    logic [0:0] b;
    cyc = 1;
    pi = 0;
    done_cyc = -1;
    while (cyc <= 200) begin
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      check("busy_in_frame", busy, 1);
      check("load_ready_in_frame", load_ready, 0);
      case (mode)
        0: ser_ready = 1'b1;
        1: begin
          ser_ready = pat[pi % 6];
          pi++;
        end
        default: ser_ready = 1'($urandom_range(0, 1));
      endcase
      if (inject) begin
        load_valid = 1'b1;
        load_data  = 16'hFFFF;
      end
      stalled  = 1'b0;
      prev_out = 1'b0;
      if (ser_valid === 1'b1 && ser_ready) begin
        check("bit_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          check("ser_bit", ser_out, b);
        end
      end else if (ser_valid === 1'b1) begin
        stalled  = 1'b1;
        prev_out = ser_out;
      end
      step();
      cyc++;
      if (stalled) begin
        check("stall_valid", ser_valid, 1);
        check("stall_out", ser_out, prev_out);
      end
    end
    load_valid = 1'b0;
    ser_ready  = 1'b0;
    check("drain_finished", done_cyc > 0, 1);
    check("all_bits_sent", exp_q.size(), 0);
    step();
    check("done_single_cycle", done, 0);
    check("load_ready_after_done", load_ready, 1);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    int dc;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    ser_ready  = 1'b0;

    // Reset held for two cycles.
    step();
    step();
    rst = 1'b0;
    check_idle("reset");
    step();
    check_idle("reset_hold");

    // A stray ready in IDLE must not create a valid bit.
    ser_ready = 1'b1;
    step();
    check_idle("stray_ready");
    step();
    check_idle("stray_ready2");
    ser_ready = 1'b0;

    // A load asserted together with reset is dropped.
    rst        = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'hBEEF;
    step();
    rst        = 1'b0;
    load_valid = 1'b0;
    check_idle("load_with_reset");
    step();
    check_idle("load_with_reset2");

    // Full frame with no stalls: checks latency and throughput.
    load_word(16'hA5C3);
    drain(0, 1'b0, dc);
    check("done_cycle_no_stall", dc, W + 1 + EXTRA);

    // Backpressure pattern.
    load_word(16'h8001);
    drain(1, 1'b0, dc);

    // A load attempt in mid-frame is ignored.
    load_word(16'h1234);
    drain(0, 1'b1, dc);
    check("done_cycle_inject", dc, W + 1 + EXTRA);
    check_idle("after_inject");

    // Reset after five accepted bits.
    load_word(16'h5A5A);
    ser_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_check : begin
        logic [0:0] eb;
        eb = exp_q.pop_front();
        check("pre_reset_bit", ser_out, eb);
      end
      step();
    end
    rst = 1'b1;
    step();
    rst       = 1'b0;
    ser_ready = 1'b0;
    exp_q.delete();
    check_idle("mid_frame_reset");
    step();
    check_idle("mid_frame_reset2");
    load_word(16'h0001);
    drain(0, 1'b0, dc);
    check("done_cycle_after_reset", dc, W + 1 + EXTRA);

    // Random words with random receiver readiness.
    for (int k = 0; k < 4; k++) begin
      load_word(16'($urandom));
      drain(2, 1'b0, dc);
    end

`ifdef PISO_TX_PARITY_EN
    // Parity bit: odd and even population counts.
    load_word(16'h0007);
    drain(0, 1'b0, dc);
    check("parity_done_cycle", dc, W + 2);
    load_word(16'h0003);
    drain(1, 1'b0, dc);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in/serial-out transmitter with a load handshake. It accepts a WIDTH-bit word from the register datapath and transmits it bit by bit, MSB first, over a valid/ready serial interface, then pulses `done`. It is the read-out end of the parameterizable register path: a word is captured in parallel and drained serially toward an off-block receiver.

## Interface
- `WIDTH`, default 16: word width in bits; legal range ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `load_valid`  in  1  producer presents `load_data`.
- `load_ready`  out  1  block can accept a word. High only in IDLE.
- `load_data`  in  WIDTH  word to transmit; sampled only on an accepted load.
- `ser_valid`  out  1  `ser_out` carries a valid bit.
- `ser_ready`  in  1  receiver accepts the current bit.
- `ser_out`  out  1  serial data bit.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  single-cycle pulse after the last bit of a frame is accepted.

## Operation
- **States:** IDLE, SHIFT, PARITY (present only with `PISO_TX_PARITY_EN`), DONE.
- **Outputs by state:** all outputs decode from the state. `ser_out` is 0 whenever `ser_valid` = 0.
  - IDLE: `load_ready`=1, `ser_valid`=0, `busy`=0, `done`=0.
  - SHIFT / PARITY: `ser_valid`=1, `load_ready`=0, `busy`=1.
  - DONE: `done`=1, `busy`=1, `load_ready`=0, `ser_valid`=0.
- **Load (IDLE):** `load_valid` & `load_ready` →
  - `shreg` <= `load_data`
  - `bit_cnt` <= 0
  - go to SHIFT
- **SHIFT:**
  - `ser_out` = `shreg[WIDTH-1]`.
  - On `ser_valid` & `ser_ready`: shift `shreg` left by one (zero fill) and increment `bit_cnt`.
  - When the accepted bit has `bit_cnt` = WIDTH-1: go to PARITY if the parity feature is compiled in, else DONE.
- **PARITY:** `ser_out` = stored parity bit. On `ser_ready` → DONE.
- **DONE:** lasts exactly one cycle, then IDLE.
- **Bit counter:** `bit_cnt` is $clog2(WIDTH) bits wide and never wraps within a frame.
- **Loads outside IDLE:** `load_valid` is ignored in every state other than IDLE. `load_data` changes outside IDLE have no effect.
- **Stalls:** `ser_ready` = 0 in SHIFT or PARITY stalls the frame. `ser_out`, `ser_valid` and internal state stay frozen.
- **Stray ready:** `ser_ready` while `ser_valid` = 0 is ignored.
- **Reset mid-frame:** `rst` aborts the frame. The next cycle is IDLE with no `done` pulse, and the partial word is discarded.
- **Simultaneous load and reset:** `load_valid` during `rst` is not accepted; reset wins.

## Timing
- **Reset:** `rst` high at edge N → from cycle N+1 the state is IDLE and:
  - `load_ready`=1
  - `ser_valid`=0, `ser_out`=0
  - `busy`=0, `done`=0
  - `shreg`=0, `bit_cnt`=0
- **Load to first bit:** load accepted at edge N → MSB on `ser_out` with `ser_valid`=1 in cycle N+1.
- **Throughput with `ser_ready` held high:**
  - Data bits occupy cycles N+1 … N+WIDTH.
  - `done`=1 in cycle N+WIDTH+1.
  - `load_ready`=1 in cycle N+WIDTH+2.
  - One word per WIDTH+2 cycles; WIDTH+3 with parity.
- **Bit transfer rule:** each bit transfers on the rising edge where `ser_valid` & `ser_ready`.
- **No combinational paths:** there is no input-to-output combinational path (`ser_ready` does not drive `ser_out` in the same cycle).

## Configuration
- **`PISO_TX_PARITY_EN` defined:**
  - An even-parity bit (XOR of all `load_data` bits) is registered on load.
  - It is transmitted as bit WIDTH+1 in the PARITY state, using the same handshake and stall rules as data bits.
- **Undefined:** no PARITY state and no parity register; SHIFT goes directly to DONE.

## Test plan
1. **Reset:** `rst`=1 for 2 cycles, then 0 → `load_ready`=1, `ser_valid`=0, `ser_out`=0, `busy`=0, `done`=0 on the first post-reset cycle.
2. **Full frame, no stalls:**
   - Stimulus: WIDTH=16, load 0xA5C3, `ser_ready`=1.
   - Required: `ser_out` = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 over 16 consecutive cycles starting the cycle after the load.
   - Then `done`=1 for one cycle, then `load_ready`=1.
3. **Backpressure:**
   - Stimulus: load 0x8001 with `ser_ready` pattern 1,0,0,1,0,1,…
   - Required: `ser_out` and `ser_valid` hold steady during every stall; exactly 16 bits are accepted, first and last = 1, the rest 0.
4. **Load during frame:** `load_valid`=1 with `load_data`=0xFFFF during SHIFT → ignored; the frame completes with the original word, and `load_ready` stays 0 until after `done`.
5. **Reset mid-frame:**
   - Stimulus: `rst` after 5 accepted bits.
   - Required: IDLE on the next cycle with no `done` pulse. A subsequent load of 0x0001 transmits 15 zeros then a 1.
6. **Parity (with `PISO_TX_PARITY_EN`):**
   - 0x0007 → 17th bit = 1, `done` at cycle N+18.
   - 0x0003 → 17th bit = 0.
